md_unit_param: RTL and testbench
================================

Name: md_unit_param

Overview:
- Parametrised multiply/divide unit for the E stage of the five-stage MIPS pipeline.
- Successor to the fixed 32-bit mult/div block. Adds:
  - configurable width and latencies
  - multiply-accumulate (madd/maddu/msub/msubu)
  - an abort input for pipeline flush
  - a combined stall request for the D-stage hazard unit
- HI/LO are architectural state held here and are read combinationally by the E-stage result mux.

Parameters:
- WIDTH, 32: operand and HI/LO width.
- MUL_LAT, 5: busy cycles for mult/multu/madd/maddu/msub/msubu; must be ≥1.
- DIV_LAT, 10: busy cycles for div/divu; must be ≥1.
- CNT_W, 4: counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high; clears all state
- start  in  1  E-stage instruction is an md op (op valid this cycle)
- op  in  4  operation code (md_pkg encoding)
- a  in  WIDTH  forwarded rs value
- b  in  WIDTH  forwarded rt value
- cancel  in  1  abort any in-flight op and ignore start this cycle
- hi  out  WIDTH  current HI
- lo  out  WIDTH  current LO
- busy  out  1  multi-cycle op in progress
- stall_req  out  1  = busy | (start & op is multi-cycle & ~cancel); consumed by D-stage block logic for mfhi/mflo/md ops

Behaviour:
- Reset (sync, highest priority): hi=0, lo=0, busy=0, counter=0, pending result=0, state IDLE.
- States: IDLE and RUN.
- IDLE, start=1, cancel=0:
  - MTHI/MTLO: write a to HI/LO at this edge; no busy; state stays IDLE.
  - Multi-cycle op:
    - compute result at this edge into pend_hi/pend_lo
    - load counter with MUL_LAT or DIV_LAT
    - go to RUN; busy=1 from the next cycle
- RUN:
  - counter decrements each edge.
  - When counter==1 at an edge: commit pend to HI/LO, busy falls, return to IDLE.
  - Net effect: an op started at edge T keeps busy=1 for exactly LAT cycles, and new HI/LO are visible after edge T+LAT.
- start while busy=1 is ignored; hazard logic guarantees it never occurs, and the bench checks it has no effect.
- cancel=1 in any state:
  - next edge returns to IDLE, busy=0
  - pending result discarded; HI/LO keep their pre-op values
  - a same-cycle start (including mthi/mtlo) is ignored
- Arithmetic (full 2·WIDTH product):
  - mult/multu: {HI,LO} = a*b, signed/unsigned respectively.
  - madd/maddu: {HI,LO} = {HI,LO} + a*b.
  - msub/msubu: {HI,LO} = {HI,LO} − a*b.
  - Accumulate ops use the HI/LO values at the start edge; wrap mod 2^(2·WIDTH).
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of a.
  - divu: unsigned quotient/remainder.
  - Overflow case div(−2^(W−1), −1): LO = 0x80000000, HI = 0.
- Divide by zero (b==0):
  - still takes DIV_LAT cycles with busy asserted
  - HI/LO left unchanged at commit
- Undefined op codes with start=1: treated as no-op; no busy, no state change.
- hi/lo outputs are plain register outputs; there is no bypass of pending results.

Decomposition:
- Package md_pkg holds:
  - op encoding: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5, MD_MADD=6, MD_MADDU=7, MD_MSUB=8, MD_MSUBU=9
  - state enum IDLE/RUN
  - function is_multicycle(op)
- One sub-module, md_latency_ctr: loadable down-counter with done pulse and clear. It owns busy and cancel handling.
- Arithmetic stays in the top module.

Test Plan:
- Reset, then mult a=0xFFFFFFFE (−2), b=3 → busy high for exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- divu a=7, b=2, then div a=−7 (0xFFFFFFF9), b=2:
  - divu → lo=3, hi=1
  - div → lo=0xFFFFFFFD, hi=0xFFFFFFFF
  - each busy for exactly 10 cycles
- mthi 0x1, mtlo 0x0, then maddu a=0xFFFFFFFF, b=2 → hi=0x2, lo=0xFFFFFFFE. Follow with msub a=1, b=1 → hi=0x2, lo=0xFFFFFFFD.
- div a=5, b=0 with hi=0xAA, lo=0x55 beforehand → busy for 10 cycles; hi=0xAA, lo=0x55 unchanged.
- Start mult 6×7, assert cancel on the 3rd busy cycle → busy=0 next cycle; hi/lo unchanged. Then a new mult 2×3 → lo=6.
- Same-cycle and overlap checks:
  - start=1 with op=mthi and cancel=1 → hi unchanged.
  - start during busy → ignored.
  - div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
  - stall_req high in the start cycle of a multi-cycle op; low for mthi.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encoding, FSM states
// and small op-classification helpers.
package md_pkg;

  localparam logic [3:0] MD_MULT  = 4'd0;
  localparam logic [3:0] MD_MULTU = 4'd1;
  localparam logic [3:0] MD_DIV   = 4'd2;
  localparam logic [3:0] MD_DIVU  = 4'd3;
  localparam logic [3:0] MD_MTHI  = 4'd4;
  localparam logic [3:0] MD_MTLO  = 4'd5;
  localparam logic [3:0] MD_MADD  = 4'd6;
  localparam logic [3:0] MD_MADDU = 4'd7;
  localparam logic [3:0] MD_MSUB  = 4'd8;
  localparam logic [3:0] MD_MSUBU = 4'd9;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  // True for every op that occupies the unit for more than one cycle.
  function automatic logic is_multicycle(input logic [3:0] op);
    logic r;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
      MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: r = 1'b1;
      default:                              r = 1'b0;
    endcase
    return r;
  endfunction

  // True for the two divide ops (they use the divide latency).
  function automatic logic is_div(input logic [3:0] op);
    logic r;
    case (op)
      MD_DIV, MD_DIVU: r = 1'b1;
      default:         r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/md_latency_ctr.sv
// Busy tracker for the multiply/divide unit: a loadable down-counter with an
// IDLE/RUN state machine. Cancel acts as a synchronous clear. o_done is high
// during the last busy cycle so the owner can commit at that edge.
module md_latency_ctr
  import md_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_cancel,
  output logic             o_busy,
  output logic             o_done
);

  md_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;

  // State, counter and registered busy flag; cancel returns to IDLE at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_busy  <= 1'b0;
    end else if (i_cancel) begin
      r_state <= IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_load) begin
            r_state <= RUN;
            r_cnt   <= i_load_val;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= {CNT_W{1'b0}};
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy & (r_cnt == CNT_W'(1));

endmodule

// File: rtl/md_unit_param.sv
// Parametrised multiply/divide unit with HI/LO state, multiply-accumulate,
// flush cancel and a stall request for the decode-stage hazard logic.
// The result is computed at the start edge and held pending until the
// latency counter expires, so HI/LO change only at commit.
module md_unit_param
  import md_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall_req
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [CNT_W-1:0] MUL_LAT_C = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_LAT_C = CNT_W'(DIV_LAT);

  logic [WIDTH-1:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic             r_pend_wr;

  logic             w_busy, w_done, w_start_ok, w_load;
  logic [CNT_W-1:0] w_lat;

  // Products over the full double width; truncation to W2 bits is exact.
  logic [W2-1:0] w_acc, w_a_sx, w_b_sx, w_a_zx, w_b_zx, w_sprod, w_uprod;
  assign w_acc   = {r_hi, r_lo};
  assign w_a_sx  = {{WIDTH{a[WIDTH-1]}}, a};
  assign w_b_sx  = {{WIDTH{b[WIDTH-1]}}, b};
  assign w_a_zx  = {{WIDTH{1'b0}}, a};
  assign w_b_zx  = {{WIDTH{1'b0}}, b};
  assign w_sprod = w_a_sx * w_b_sx;
  assign w_uprod = w_a_zx * w_b_zx;

  // Divide by zero substitutes 1 so the datapath stays defined; the result
  // is then dropped at commit.
  logic             w_b_zero, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_b_safe, w_a_mag, w_b_mag, w_sq_mag, w_sr_mag;
  logic [WIDTH-1:0] w_sq, w_sr, w_uq, w_ur;
  assign w_b_zero = (b == {WIDTH{1'b0}});
  assign w_b_safe = w_b_zero ? WIDTH'(1) : b;
  assign w_uq     = a / w_b_safe;
  assign w_ur     = a % w_b_safe;
  assign w_a_neg  = a[WIDTH-1];
  assign w_b_neg  = w_b_safe[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~a + WIDTH'(1)) : a;
  assign w_b_mag  = w_b_neg ? (~w_b_safe + WIDTH'(1)) : w_b_safe;
  assign w_sq_mag = w_a_mag / w_b_mag;
  assign w_sr_mag = w_a_mag % w_b_mag;
  // Quotient truncates toward zero; remainder takes the sign of a. The
  // most-negative / -1 case naturally yields quotient 0x80..0, remainder 0.
  assign w_sq     = (w_a_neg ^ w_b_neg) ? (~w_sq_mag + WIDTH'(1)) : w_sq_mag;
  assign w_sr     = w_a_neg ? (~w_sr_mag + WIDTH'(1)) : w_sr_mag;

  logic [W2-1:0] w_res;
  logic          w_res_wr;

  // Select the result of the requested multi-cycle op and whether it commits.
  always_comb begin
    w_res    = {W2{1'b0}};
    w_res_wr = 1'b0;
    case (op)
      MD_MULT:  begin w_res = w_sprod;         w_res_wr = 1'b1; end
      MD_MULTU: begin w_res = w_uprod;         w_res_wr = 1'b1; end
      MD_MADD:  begin w_res = w_acc + w_sprod; w_res_wr = 1'b1; end
      MD_MADDU: begin w_res = w_acc + w_uprod; w_res_wr = 1'b1; end
      MD_MSUB:  begin w_res = w_acc - w_sprod; w_res_wr = 1'b1; end
      MD_MSUBU: begin w_res = w_acc - w_uprod; w_res_wr = 1'b1; end
      MD_DIV:   begin w_res = {w_sr, w_sq};    w_res_wr = ~w_b_zero; end
      MD_DIVU:  begin w_res = {w_ur, w_uq};    w_res_wr = ~w_b_zero; end
      default:  begin w_res = {W2{1'b0}};      w_res_wr = 1'b0; end
    endcase
  end

  assign w_start_ok = start & ~cancel & ~w_busy;
  assign w_load     = w_start_ok & is_multicycle(op);
  assign w_lat      = is_div(op) ? DIV_LAT_C : MUL_LAT_C;

  md_latency_ctr #(
    .CNT_W(CNT_W)
  ) u_ctr (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_load_val(w_lat),
    .i_cancel  (cancel),
    .o_busy    (w_busy),
    .o_done    (w_done)
  );

  // HI/LO and pending-result registers: direct moves, capture and commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi      <= {WIDTH{1'b0}};
      r_lo      <= {WIDTH{1'b0}};
      r_pend_hi <= {WIDTH{1'b0}};
      r_pend_lo <= {WIDTH{1'b0}};
      r_pend_wr <= 1'b0;
    end else if (cancel) begin
      r_pend_wr <= 1'b0;
    end else if (w_done) begin
      if (r_pend_wr) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
      r_pend_wr <= 1'b0;
    end else if (w_start_ok) begin
      case (op)
        MD_MTHI: r_hi <= a;
        MD_MTLO: r_lo <= a;
        default: begin
          if (w_load) begin
            r_pend_hi <= w_res[W2-1:WIDTH];
            r_pend_lo <= w_res[WIDTH-1:0];
            r_pend_wr <= w_res_wr;
          end
        end
      endcase
    end
  end

  assign hi        = r_hi;
  assign lo        = r_lo;
  assign busy      = w_busy;
  assign stall_req = w_busy | (start & is_multicycle(op) & ~cancel);

endmodule

// File: tb/tb_md_unit_param.sv
// Self-checking bench for md_unit_param: expected HI/LO pairs are queued when
// an op is issued and compared when the unit goes idle again.
module tb_md_unit_param;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        cancel = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, stall_req;

  int checks = 0;
  int failures = 0;
  logic [63:0] sb_q[$];

  md_unit_param #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .hi(hi), .lo(lo), .busy(busy), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  // Drive a one-cycle start at a negedge; report stall_req in that cycle.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic st);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    #1 st = stall_req;
    @(negedge clk);
    start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
  endtask

  // Count remaining busy cycles (sampled at negedges), bounded.
  task automatic wait_idle(output int n, output bit to);
    n = 0; to = 1'b0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) to = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({hi, lo, busy, stall_req} !== {64'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset: hi=%h lo=%h busy=%b stall=%b, required all zero", hi, lo, busy, stall_req);
    end
  endtask

  // Issue one multi-cycle op, then check stall, latency and scoreboard result.
  task automatic test_op(input string nm, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] exp_r, input int lat);
    logic st; int n; bit to; logic [63:0] e;
    sb_q.push_back(exp_r);
    issue(o, x, y, st);
    wait_idle(n, to);
    e = sb_q.pop_front();
    checks++;
    if (st !== 1'b1) begin failures++; $display("FAIL %s stall: got %b required 1", nm, st); end
    checks++;
    if (to || n !== lat) begin failures++; $display("FAIL %s busy_cycles: got %0d required %0d", nm, n, lat); end
    checks++;
    if ({hi, lo} !== e) begin failures++; $display("FAIL %s result: got %h_%h required %h", nm, hi, lo, e); end
  endtask

  task automatic test_move(input logic [3:0] o, input logic [31:0] x, input logic [63:0] exp_r);
    logic st;
    issue(o, x, 32'd0, st);
    checks++;
    if (st !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL move busy/stall: got %b/%b required 0/0", busy, st); end
    checks++;
    if ({hi, lo} !== exp_r) begin failures++; $display("FAIL move result: got %h_%h required %h", hi, lo, exp_r); end
  endtask

  task automatic test_mult();
    test_op("mult_neg", MD_MULT, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, 5);
  endtask

  task automatic test_div();
    test_op("divu", MD_DIVU, 32'd7, 32'd2, {32'd1, 32'd3}, 10);
    test_op("div_neg", MD_DIV, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 10);
  endtask

  task automatic test_mac();
    test_move(MD_MTHI, 32'd1, {32'd1, 32'hFFFFFFFD});
    test_move(MD_MTLO, 32'd0, {32'd1, 32'd0});
    test_op("maddu", MD_MADDU, 32'hFFFFFFFF, 32'd2, {32'd2, 32'hFFFFFFFE}, 5);
    test_op("msub", MD_MSUB, 32'd1, 32'd1, {32'd2, 32'hFFFFFFFD}, 5);
  endtask

  task automatic test_div_zero();
    test_move(MD_MTHI, 32'hAA, {32'hAA, 32'hFFFFFFFD});
    test_move(MD_MTLO, 32'h55, {32'hAA, 32'h55});
    test_op("div_zero", MD_DIV, 32'd5, 32'd0, {32'hAA, 32'h55}, 10);
  endtask

  task automatic test_cancel();
    logic st;
    issue(MD_MULT, 32'd6, 32'd7, st);   // now in busy cycle 1
    @(negedge clk);                      // busy cycle 2
    @(negedge clk);                      // busy cycle 3
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL cancel busy: got %b required 0", busy); end
    checks++;
    if ({hi, lo} !== {32'hAA, 32'h55}) begin failures++; $display("FAIL cancel keep: got %h_%h required aa_55", hi, lo); end
    repeat (6) @(negedge clk);
    checks++;
    if ({hi, lo} !== {32'hAA, 32'h55}) begin failures++; $display("FAIL cancel late: got %h_%h required aa_55", hi, lo); end
    test_op("mult_after_cancel", MD_MULT, 32'd2, 32'd3, {32'd0, 32'd6}, 5);
  endtask

  task automatic test_same_cycle_cancel();
    @(negedge clk);
    start = 1'b1; op = MD_MTHI; a = 32'h123; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; a = 32'd0;
    checks++;
    if (hi !== 32'd0) begin failures++; $display("FAIL mthi_cancel: got hi=%h required 0", hi); end
    start = 1'b1; op = MD_MULT; a = 32'd9; b = 32'd9; cancel = 1'b1;
    #1;
    checks++;
    if (stall_req !== 1'b0) begin failures++; $display("FAIL stall_cancel: got %b required 0", stall_req); end
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; a = 32'd0; b = 32'd0;
    checks++;
    if (busy !== 1'b0 || lo !== 32'd6) begin failures++; $display("FAIL mult_cancel: busy=%b lo=%h required 0/6", busy, lo); end
  endtask

  task automatic test_back_to_back();
    logic st; int n; bit to; logic [63:0] e;
    sb_q.push_back({32'd0, 32'd12});
    issue(MD_MULT, 32'd3, 32'd4, st);   // busy cycle 1
    start = 1'b1; op = MD_MTHI; a = 32'hDEAD;
    @(negedge clk);                      // busy cycle 2 with start present
    start = 1'b1; op = MD_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    wait_idle(n, to);
    e = sb_q.pop_front();
    checks++;
    if (to || n + 2 !== 5) begin failures++; $display("FAIL overlap busy_cycles: got %0d required 5", n + 2); end
    checks++;
    if ({hi, lo} !== e) begin failures++; $display("FAIL overlap result: got %h_%h required %h", hi, lo, e); end
    test_op("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 10);
    test_move(4'hF, 32'h77, {32'd0, 32'h80000000});
  endtask

  task automatic test_random_mult();
    logic [31:0] x, y; longint p; longint unsigned pu;
    for (int i = 0; i < 3; i++) begin
      x = $urandom; y = $urandom;
      p = longint'($signed(x)) * longint'($signed(y));
      test_op("mult_rand", MD_MULT, x, y, p, 5);
      pu = {32'd0, x} * {32'd0, y};
      test_op("multu_rand", MD_MULTU, x, y, pu, 5);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mac();
    test_div_zero();
    test_cancel();
    test_same_cycle_cancel();
    test_back_to_back();
    test_random_mult();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
